// File: rtl/gen_output_fifo.sv
// gen_output_fifo: launches one generator run and buffers each yielded 4-lane tuple
// in a small FIFO. The FIFO is presented to a consumer over a valid/ready handshake.
// done pulses once the generator has finished and every buffered tuple has been taken.
//
// state  | meaning
// IDLE   | waiting for a host start pulse
// LAUNCH | gen_start high for this single cycle; generator outputs ignored
// RUN    | generator running; each gen_valid pushes a tuple, gen_done ends the run
// DRAIN  | no more pushes; wait for the consumer to empty the FIFO, then pulse done
module gen_output_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      _clock,
    input  logic                      _reset_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      gen_start,
    input  logic                      gen_valid,
    input  logic                      gen_done,
    input  logic signed [WIDTH-1:0]   gen_out0,
    input  logic signed [WIDTH-1:0]   gen_out1,
    input  logic signed [WIDTH-1:0]   gen_out2,
    input  logic signed [WIDTH-1:0]   gen_out3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_data0,
    output logic signed [WIDTH-1:0]   out_data1,
    output logic signed [WIDTH-1:0]   out_data2,
    output logic signed [WIDTH-1:0]   out_data3,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_LEVEL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;

    state_t               state;
    logic [4*WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 do_write;

    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign push      = gen_valid && (state == RUN);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_write  = push && (!full || pop);

    // The head is read straight from storage, so it holds steady while the consumer stalls.
    assign {out_data3, out_data2, out_data1, out_data0} = mem[rd_ptr];

    // Run sequencing: launch pulse, capture window, drain, completion pulse.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_start <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done      <= 1'b0;
            gen_start <= 1'b0;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LAUNCH;
                        busy      <= 1'b1;
                        gen_start <= 1'b1;
                        overflow  <= 1'b0;
                    end
                end
                LAUNCH: state <= RUN;
                RUN: begin
                    if (gen_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Tuple storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wr_ptr] <= {gen_out3, gen_out2, gen_out1, gen_out0};
        end
    end

endmodule
